// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: one bit per clock, SLL/SRL/SRA and optional ROL.
// Build option: define SEQ_SHIFTER_ROTATE_EN to make mode 2'b11 a rotate-left; otherwise it aliases SLL.

module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // SHIFT | one-bit shift per cycle while the down-counter runs
  // DONE  | single cycle: out_data freshly updated, done asserted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [1:0] MODE_ROL = 2'b11;
`endif

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     work, work_nxt;
  logic [SHAMT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]           mode_q, mode_nxt;
  logic [WIDTH-1:0]     out_nxt;
  logic [WIDTH-1:0]     shifted;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SRL: r = {1'b0, v[WIDTH-1:1]};
      MODE_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
`endif
      default:  r = {v[WIDTH-2:0], 1'b0};
    endcase
    return r;
  endfunction

  assign shifted = shift_one(work, mode_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      mode_q   <= MODE_SLL;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      work     <= work_nxt;
      cnt      <= cnt_nxt;
      mode_q   <= mode_nxt;
      out_data <= out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    out_nxt   = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt = in_data;
          cnt_nxt  = shamt;
          mode_nxt = mode;
          // A zero shift completes on the accepting edge itself.
          if (shamt == '0) begin
            state_nxt = DONE;
            out_nxt   = in_data;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          state_nxt = DONE;
          out_nxt   = shifted;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, meaning shift-amount width; WIDTH SHALL equal 2**SHAMT_W.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port start  input  1  SHALL request an operation, sampled only in IDLE.
REQ-006 Port in_data  input  WIDTH  SHALL be the operand, captured with start.
REQ-007 Port shamt  input  SHAMT_W  SHALL be the shift amount (0..WIDTH-1), captured with start.
REQ-008 Port mode  input  2  SHALL select the operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL; captured with start.
REQ-009 Port out_data  output  WIDTH  SHALL carry the last completed result, registered.
REQ-010 Port busy  output  1  SHALL be high while an operation is in progress.
REQ-011 Port done  output  1  SHALL pulse high for one cycle when out_data is updated.

Function
REQ-012 FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1: SHALL capture in_data into a working register, shamt into a down-counter, and mode; next state SHIFT if shamt!=0, else DONE.
REQ-014 SHIFT: each cycle SHALL shift working register by exactly one bit per mode and decrement counter; when counter equals 1 at the edge, next state DONE.
REQ-015 SLL fills LSB with 0; SRL fills MSB with 0; SRA replicates MSB; ROL moves MSB into LSB.
REQ-016 On the edge entering DONE, out_data SHALL load the final working value; the DONE state SHALL last one cycle, then IDLE.
REQ-017 Latency: done SHALL be high in the cycle after the (shamt+1)th rising edge counting the edge that sampled start as edge 1 (shamt=0 -> 1 cycle, out_data=in_data).
REQ-018 busy SHALL be high in SHIFT and DONE, low in IDLE; done SHALL be high only in DONE.
REQ-019 start while busy (including the DONE cycle) SHALL be ignored; in_data/shamt/mode changes during an operation SHALL not affect it.
REQ-020 out_data SHALL hold its value between completions, including while a new operation is shifting.
REQ-021 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, out_data 0, busy 0, done 0, counter 0, working register 0, regardless of clock.
REQ-023 Reset mid-operation SHALL abort it with no done pulse; first start after rst release SHALL behave as from power-up.

Configuration
REQ-024 Macro SEQ_SHIFTER_ROTATE_EN defined: mode 11 SHALL perform ROL per REQ-015.
REQ-025 Macro SEQ_SHIFTER_ROTATE_EN undefined: mode 11 SHALL behave identically to SLL and no rotate logic SHALL be present.

Verification (WIDTH=32)
REQ-026 in_data=255, shamt=2, mode=00, one-cycle start -> done after 3 cycles, out_data=1020, busy high for 3 cycles.
REQ-027 in_data=0x80000000, shamt=4, mode=10 -> out_data=0xF8000000; same with mode=01 -> 0x08000000; each done after 5 cycles.
REQ-028 in_data=0x80000001, shamt=1, mode=11 -> out_data=0x00000003 with SEQ_SHIFTER_ROTATE_EN, 0x00000002 without.
REQ-029 shamt=0, in_data=0x12345678 -> done after 1 cycle, out_data=0x12345678; shamt=31, in_data=1, mode=00 -> done after 32 cycles, out_data=0x80000000.
REQ-030 Start SLL shamt=8 on 0xFF; pulse start with different operands at cycle 3 -> ignored, out_data=0xFF00 at cycle 9; then start again immediately after DONE -> accepted.
REQ-031 Assert rst asynchronously mid-SHIFT -> busy, done, out_data go 0 without clock edge; no done pulse follows; next operation correct.
